// File: rtl/ms_serial_pkg.sv
// ms_serial_pkg: shared FSM state type and sizing helper for the ms_serial radix-2 cores.
package ms_serial_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    function automatic int cnt_w(input int dw);
        return $clog2(2 * dw);
    endfunction
endpackage

// File: rtl/ms_serial_by2_div_step.sv
// ms_serial_by2_div_step: one combinational restoring-division step on a DW+1 bit partial remainder.
module ms_serial_by2_div_step #(
    parameter int DW = 5
) (
    input  logic [DW:0]   r_i,
    input  logic          bit_i,
    input  logic [DW-1:0] divisor_i,
    output logic [DW:0]   r_o,
    output logic          q_bit_o
);
    logic [DW:0] r_sh;
    assign r_sh = {r_i[DW-1:0], bit_i};
    // r_i[DW] is only ever set when the divisor is 0, where the quotient bit is 1 regardless
    assign q_bit_o = r_i[DW] | (r_sh >= {1'b0, divisor_i});
    assign r_o = q_bit_o ? r_sh - {1'b0, divisor_i} : r_sh;
endmodule

// File: rtl/ms_serial_by2_div.sv
// ms_serial_by2_div: MSB-first radix-2 serial restoring divider, 2*DW-bit dividend by DW-bit divisor.
module ms_serial_by2_div
    import ms_serial_pkg::*;
#(
    parameter int DATA_WIDTH = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [2*DATA_WIDTH-1:0] dividend_in,
    input  logic [DATA_WIDTH-1:0]   divisor_in,
    output logic [2*DATA_WIDTH-1:0] quotient_out,
    output logic [DATA_WIDTH-1:0]   remainder_out,
    output logic                    div_by_zero,
    output logic                    busy,
    output logic                    done
);
    localparam int DW = DATA_WIDTH;
    localparam int CW = cnt_w(DW);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2*DW-1:0] dvd_q, dvd_d, quo_q, quo_d, quo_out_q, quo_out_d;
    logic [DW-1:0] dvs_q, dvs_d, rem_out_q, rem_out_d;
    logic [DW:0]   r_q, r_d, r_nxt;
    logic          q_bit, dbz_q, dbz_d;

    ms_serial_by2_div_step #(.DW(DW)) u_step (
        .r_i       (r_q),
        .bit_i     (dvd_q[2*DW-1]),
        .divisor_i (dvs_q),
        .r_o       (r_nxt),
        .q_bit_o   (q_bit)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        r_d       = r_q;
        quo_d     = quo_q;
        quo_out_d = quo_out_q;
        rem_out_d = rem_out_q;
        dbz_d     = dbz_q;
        case (state_q)
            IDLE: if (en) begin
                state_d = RUN;
                dvd_d   = dividend_in;
                dvs_d   = divisor_in;
                r_d     = '0;
                quo_d   = '0;
                cnt_d   = CW'(2 * DW - 1);
            end
            RUN: begin
                dvd_d = dvd_q << 1;
                r_d   = r_nxt;
                quo_d = {quo_q[2*DW-2:0], q_bit};
                cnt_d = cnt_q - CW'(1);
                // results are published on the final step so they are valid throughout DONE
                if (cnt_q == '0) begin
                    state_d   = DONE;
                    quo_out_d = {quo_q[2*DW-2:0], q_bit};
                    rem_out_d = r_nxt[DW-1:0];
                    dbz_d     = dvs_q == '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            r_q       <= '0;
            quo_q     <= '0;
            quo_out_q <= '0;
            rem_out_q <= '0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            r_q       <= r_d;
            quo_q     <= quo_d;
            quo_out_q <= quo_out_d;
            rem_out_q <= rem_out_d;
            dbz_q     <= dbz_d;
        end
    end

    assign quotient_out  = quo_out_q;
    assign remainder_out = rem_out_q;
    assign div_by_zero   = dbz_q;
    assign busy          = state_q != IDLE;
    assign done          = state_q == DONE;
endmodule
